// File: rtl/phase_scheduler.sv
// ============================================================================
// Module   : phase_scheduler
// Purpose  : Demand-driven round-robin phase scheduler for one intersection.
//            It arbitrates between the North approach, the East approach
//            and the pedestrian walk. Min/max green, yellow and all-red
//            timing are measured in ticks of an external timebase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_scheduler #(
    parameter int GREEN_MIN = 10,  // green ticks before pre-emption is allowed
    parameter int GREEN_MAX = 30,  // green cap while own approach keeps requesting
    parameter int YELLOW_T  = 6,   // yellow duration in ticks
    parameter int ALLRED_T  = 2,   // all-red clearance duration in ticks
    parameter int WALK_T    = 15,  // pedestrian walk duration in ticks
    parameter int CW        = 5    // counter width, GREEN_MAX must fit
) (
    input  logic          clk,
    input  logic          reset,        // synchronous, active low
    input  logic          tick,         // timebase enable pulse
    input  logic          north_req,
    input  logic          east_req,
    input  logic          ped_req,
    output logic [1:0]    grant,
    output logic [2:0]    north_light,  // {R,Y,G}
    output logic [2:0]    east_light,   // {R,Y,G}
    output logic          walk,
    output logic [2:0]    state,
    output logic [CW-1:0] counter,
    output logic [2:0]    pending       // {ped,east,north}
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_WALK   = 3'd3
    } state_t;

    // Phase codes double as the grant encoding.
    localparam logic [1:0] c_ph_north = 2'b01;
    localparam logic [1:0] c_ph_east  = 2'b10;
    localparam logic [1:0] c_ph_ped   = 2'b11;

    // Lamp patterns {R,Y,G}
    localparam logic [2:0] c_lamp_red    = 3'b100;
    localparam logic [2:0] c_lamp_yellow = 3'b010;
    localparam logic [2:0] c_lamp_green  = 3'b001;

    // Terminal counts for the fixed-length states
    localparam logic [CW-1:0] c_allred_last = CW'(ALLRED_T - 1);
    localparam logic [CW-1:0] c_yellow_last = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] c_walk_last   = CW'(WALK_T - 1);

    // Green thresholds compared against the one-bit-wider incremented count
    localparam logic [CW:0]   c_green_min_w = (CW+1)'(GREEN_MIN);
    localparam logic [CW:0]   c_green_max_w = (CW+1)'(GREEN_MAX);
    localparam logic [CW-1:0] c_green_max   = CW'(GREEN_MAX);

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    state_t        state_q,       state_d;
    logic [CW-1:0] counter_q,     counter_d;
    logic [2:0]    pending_q,     pending_d;
    logic [1:0]    cur_phase_q,   cur_phase_d;
    logic [1:0]    last_served_q, last_served_d;

    // Combinational helpers
    logic [2:0]    req_vec;
    logic [2:0]    serve_mask;
    logic [2:0]    own_mask;
    logic [2:0]    pending_set;
    logic [1:0]    next_phase;
    logic          other_demand;
    logic          own_req;
    logic [CW:0]   green_n;

    // One-hot pending bit belonging to a phase code.
    function automatic logic [2:0] phase_mask(input logic [1:0] ph);
        logic [2:0] m;
        case (ph)
            c_ph_north: m = 3'b001;
            c_ph_east:  m = 3'b010;
            c_ph_ped:   m = 3'b100;
            default:    m = 3'b000;
        endcase
        return m;
    endfunction

    // Round-robin pick N -> E -> P starting after the last served phase.
    // With nothing pending the result falls back to North.
    function automatic logic [1:0] rr_pick(input logic [2:0] pend,
                                           input logic [1:0] last);
        logic [1:0] pick;
        pick = c_ph_north;
        case (last)
            c_ph_north: begin
                if      (pend[1]) pick = c_ph_east;
                else if (pend[2]) pick = c_ph_ped;
                else if (pend[0]) pick = c_ph_north;
            end
            c_ph_east: begin
                if      (pend[2]) pick = c_ph_ped;
                else if (pend[0]) pick = c_ph_north;
                else if (pend[1]) pick = c_ph_east;
            end
            default: begin
                if      (pend[0]) pick = c_ph_north;
                else if (pend[1]) pick = c_ph_east;
                else if (pend[2]) pick = c_ph_ped;
            end
        endcase
        return pick;
    endfunction

    // Request latching, arbitration and per-state timing.
    always_comb begin
        req_vec       = {ped_req, east_req, north_req};
        own_mask      = phase_mask(cur_phase_q);

        // The requester currently holding the crossing cannot re-latch.
        case (state_q)
            ST_GREEN: serve_mask = own_mask;
            ST_WALK:  serve_mask = 3'b100;
            default:  serve_mask = 3'b000;
        endcase

        pending_set   = pending_q | (req_vec & ~serve_mask);
        next_phase    = rr_pick(pending_q, last_served_q);
        other_demand  = |(pending_q & ~own_mask);
        own_req       = |(req_vec & own_mask);
        green_n       = {1'b0, counter_q} + {{CW{1'b0}}, 1'b1};

        state_d       = state_q;
        counter_d     = counter_q;
        pending_d     = pending_set;
        cur_phase_d   = cur_phase_q;
        last_served_d = last_served_q;

        case (state_q)
            ST_ALLRED: begin
                if (tick) begin
                    if (counter_q == c_allred_last) begin
                        counter_d     = '0;
                        last_served_d = next_phase;
                        // Entering service drops the bit, beating any
                        // request that arrives on this same edge.
                        pending_d     = pending_set & ~phase_mask(next_phase);
                        if (next_phase == c_ph_ped) begin
                            state_d = ST_WALK;
                        end else begin
                            state_d     = ST_GREEN;
                            cur_phase_d = next_phase;
                        end
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
            end

            ST_GREEN: begin
                if (tick) begin
                    if (other_demand && (green_n >= c_green_min_w) &&
                        (!own_req || (green_n >= c_green_max_w))) begin
                        state_d   = ST_YELLOW;
                        counter_d = '0;
                    end else if (green_n > c_green_max_w) begin
                        // Saturate so an idle green never wraps.
                        counter_d = c_green_max;
                    end else begin
                        counter_d = green_n[CW-1:0];
                    end
                end
            end

            ST_YELLOW: begin
                if (tick) begin
                    if (counter_q == c_yellow_last) begin
                        state_d   = ST_ALLRED;
                        counter_d = '0;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
            end

            ST_WALK: begin
                if (tick) begin
                    // Walk clears straight to all-red; there is no yellow.
                    if (counter_q == c_walk_last) begin
                        state_d   = ST_ALLRED;
                        counter_d = '0;
                    end else begin
                        counter_d = counter_q + 1'b1;
                    end
                end
            end

            default: begin
                // Recover from an illegal encoding independent of tick.
                state_d   = ST_ALLRED;
                counter_d = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_ALLRED;
            counter_q     <= '0;
            pending_q     <= 3'b000;
            cur_phase_q   <= c_ph_north;
            last_served_q <= c_ph_ped;   // makes North rank first
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            pending_q     <= pending_d;
            cur_phase_q   <= cur_phase_d;
            last_served_q <= last_served_d;
        end
    end

    // Lamp, walk and grant decode straight from the registered state.
    always_comb begin
        grant       = 2'b00;
        north_light = c_lamp_red;
        east_light  = c_lamp_red;
        walk        = 1'b0;
        case (state_q)
            ST_GREEN: begin
                grant = cur_phase_q;
                if (cur_phase_q == c_ph_east) begin
                    east_light = c_lamp_green;
                end else begin
                    north_light = c_lamp_green;
                end
            end
            ST_YELLOW: begin
                if (cur_phase_q == c_ph_east) begin
                    east_light = c_lamp_yellow;
                end else begin
                    north_light = c_lamp_yellow;
                end
            end
            ST_WALK: begin
                grant = c_ph_ped;
                walk  = 1'b1;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    assign state   = state_q;
    assign counter = counter_q;
    assign pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_phase_scheduler.sv
// ============================================================================
// Module   : tb_phase_scheduler
// Purpose  : Directed bench for phase_scheduler. Stimulus pushes expected
//            phase transitions and cycle-stamped snapshots into queues;
//            a monitor pops and compares them as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_scheduler;

    // Packed observation: {state[2:0], grant[1:0], north[2:0], east[2:0], walk}
    localparam logic [11:0] K_AR = {3'd0, 2'b00, 3'b100, 3'b100, 1'b0};
    localparam logic [11:0] K_GN = {3'd1, 2'b01, 3'b001, 3'b100, 1'b0};
    localparam logic [11:0] K_GE = {3'd1, 2'b10, 3'b100, 3'b001, 1'b0};
    localparam logic [11:0] K_YN = {3'd2, 2'b00, 3'b010, 3'b100, 1'b0};
    localparam logic [11:0] K_YE = {3'd2, 2'b00, 3'b100, 3'b010, 1'b0};
    localparam logic [11:0] K_WK = {3'd3, 2'b11, 3'b100, 3'b100, 1'b1};

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       north_req;
    logic       east_req;
    logic       ped_req;
    logic [1:0] grant;
    logic [2:0] north_light;
    logic [2:0] east_light;
    logic       walk;
    logic [2:0] state;
    logic [4:0] counter;
    logic [2:0] pending;
    logic [11:0] obs;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        logic [11:0] o;
        logic [4:0]  cnt;
        logic [2:0]  pend;
        string       name;
    } spot_t;

    typedef struct {
        logic [11:0] o;
        int          dwell;
        string       name;
    } tr_t;

    spot_t spot_q[$];
    tr_t   tr_q[$];

    phase_scheduler #(
        .GREEN_MIN (10),
        .GREEN_MAX (30),
        .YELLOW_T  (6),
        .ALLRED_T  (2),
        .WALK_T    (15),
        .CW        (5)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .north_req   (north_req),
        .east_req    (east_req),
        .ped_req     (ped_req),
        .grant       (grant),
        .north_light (north_light),
        .east_light  (east_light),
        .walk        (walk),
        .state       (state),
        .counter     (counter),
        .pending     (pending)
    );

    assign obs = {state, grant, north_light, east_light, walk};

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_spot(input int c, input logic [11:0] o,
                             input logic [4:0] cnt, input logic [2:0] pend,
                             input string nm);
        spot_t s;
        s.cyc = c; s.o = o; s.cnt = cnt; s.pend = pend; s.name = nm;
        spot_q.push_back(s);
    endtask

    task automatic push_tr(input logic [11:0] o, input int dwell, input string nm);
        tr_t t;
        t.o = o; t.dwell = dwell; t.name = nm;
        tr_q.push_back(t);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: snapshots by cycle stamp, transitions whenever state changes.
    initial begin : monitor
        spot_t  sp;
        tr_t    tr;
        logic [2:0] prev_st;
        int     last_chg;
        bit     mon_on;
        mon_on   = 1'b0;
        prev_st  = 3'd0;
        last_chg = 0;
        forever begin
            @(negedge clk);
            while (spot_q.size() > 0 && spot_q[0].cyc <= cyc) begin
                sp = spot_q.pop_front();
                n_checks++;
                if (sp.cyc != cyc || obs !== sp.o || counter !== sp.cnt ||
                    pending !== sp.pend) begin
                    n_fail++;
                    $display("FAIL %s @%0d: got st=%0d gr=%b nl=%b el=%b walk=%b cnt=%0d pend=%b, want st=%0d gr=%b nl=%b el=%b walk=%b cnt=%0d pend=%b",
                             sp.name, cyc, state, grant, north_light, east_light, walk,
                             counter, pending, sp.o[11:9], sp.o[8:7], sp.o[6:4],
                             sp.o[3:1], sp.o[0], sp.cnt, sp.pend);
                end
            end
            if (!mon_on) begin
                if (cyc == 2) begin
                    prev_st  = state;
                    last_chg = cyc;
                    mon_on   = 1'b1;
                end
            end else if (state !== prev_st) begin
                n_checks++;
                if (tr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_transition @%0d: got st=%0d, want no change from st=%0d",
                             cyc, state, prev_st);
                end else begin
                    tr = tr_q.pop_front();
                    if (obs !== tr.o) begin
                        n_fail++;
                        $display("FAIL %s @%0d: got st=%0d gr=%b nl=%b el=%b walk=%b, want st=%0d gr=%b nl=%b el=%b walk=%b",
                                 tr.name, cyc, state, grant, north_light, east_light, walk,
                                 tr.o[11:9], tr.o[8:7], tr.o[6:4], tr.o[3:1], tr.o[0]);
                    end
                    n_checks++;
                    if (cyc - last_chg != tr.dwell) begin
                        n_fail++;
                        $display("FAIL %s_dwell @%0d: got %0d cycles in previous state, want %0d",
                                 tr.name, cyc, cyc - last_chg, tr.dwell);
                    end
                end
                prev_st  = state;
                last_chg = cyc;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not reach its end, want finish before 50000");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin : stim
        reset = 1'b0; tick = 1'b0;
        north_req = 1'b0; east_req = 1'b0; ped_req = 1'b0;

        // Reset, then idle: North is the default green and holds.
        push_spot(2, K_AR, 5'd0, 3'b000, "reset_state");
        push_tr(K_GN, 2, "s1_north_green");
        push_spot(4, K_GN, 5'd0, 3'b000, "s1_green_entry");
        push_spot(104, K_GN, 5'd30, 3'b000, "s1_green_saturated");
        wait_cyc(2);
        reset = 1'b1; tick = 1'b1;

        // Fresh start, east pulse at counter 3 pre-empts after GREEN_MIN.
        wait_cyc(104);
        push_tr(K_AR, 101, "s2_reset_allred");
        push_tr(K_GN, 3, "s2_north_green");
        push_spot(112, K_GN, 5'd4, 3'b010, "s2_east_latched");
        push_tr(K_YN, 10, "s2_north_yellow");
        push_tr(K_AR, 6, "s2_allred");
        push_tr(K_GE, 2, "s2_east_green");
        push_spot(126, K_GE, 5'd0, 3'b000, "s2_east_entry");
        reset = 1'b0;
        wait_cyc(106);
        reset = 1'b1;
        wait_cyc(111);
        east_req = 1'b1;
        wait_cyc(112);
        east_req = 1'b0;

        // North held with East waiting: green runs to GREEN_MAX.
        wait_cyc(126);
        push_tr(K_YE, 10, "s3_east_yellow");
        push_spot(137, K_YE, 5'd1, 3'b011, "s3_both_pending");
        push_tr(K_AR, 6, "s3_allred_a");
        push_tr(K_GN, 2, "s3_north_green");
        push_spot(144, K_GN, 5'd0, 3'b010, "s3_north_entry");
        push_tr(K_YN, 30, "s3_green_max");
        push_tr(K_AR, 6, "s3_allred_b");
        push_tr(K_GE, 2, "s3_east_green");
        push_spot(182, K_GE, 5'd0, 3'b001, "s3_east_entry");
        push_tr(K_YE, 10, "s3_east_yellow_b");
        push_tr(K_AR, 6, "s3_allred_c");
        push_tr(K_GN, 2, "s3_north_green_b");
        north_req = 1'b1;
        wait_cyc(136);
        east_req = 1'b1;
        wait_cyc(137);
        east_req = 1'b0;
        wait_cyc(182);
        north_req = 1'b0;

        // Same max-green case with a tick every 4th cycle.
        wait_cyc(200);
        push_spot(202, K_GN, 5'd0, 3'b010, "s3x4_pend");
        push_spot(205, K_GN, 5'd1, 3'b010, "s3x4_cnt_after_tick");
        push_spot(207, K_GN, 5'd1, 3'b010, "s3x4_cnt_hold");
        push_tr(K_YN, 120, "s3x4_green_max");
        push_tr(K_AR, 24, "s3x4_allred");
        push_tr(K_GE, 8, "s3x4_east_green");
        push_spot(352, K_GE, 5'd0, 3'b001, "s3x4_east_entry");
        push_tr(K_YE, 10, "s3x4_east_yellow");
        push_tr(K_AR, 6, "s3x4_allred_b");
        push_tr(K_GN, 2, "s3x4_north_green");
        north_req = 1'b1;
        east_req  = 1'b1;
        tick      = 1'b0;
        wait_cyc(201);
        east_req  = 1'b0;
        while (cyc < 352) begin
            tick = ((cyc + 1) % 4 == 0);
            @(negedge clk);
        end
        tick      = 1'b1;
        north_req = 1'b0;

        // East and Ped together, then walk; repeated presses in walk ignored.
        wait_cyc(372);
        push_spot(373, K_GN, 5'd3, 3'b110, "s4_east_ped_latched");
        push_tr(K_YN, 10, "s4_north_yellow");
        push_tr(K_AR, 6, "s4_allred_a");
        push_tr(K_GE, 2, "s4_east_green");
        push_spot(388, K_GE, 5'd0, 3'b100, "s4_east_entry");
        push_tr(K_YE, 10, "s4_east_yellow");
        push_tr(K_AR, 6, "s4_allred_b");
        push_tr(K_WK, 2, "s4_walk");
        push_spot(406, K_WK, 5'd0, 3'b000, "s4_walk_entry");
        push_spot(414, K_WK, 5'd8, 3'b000, "s6_ped_in_walk_ignored");
        push_tr(K_AR, 15, "s4_walk_end");
        push_spot(421, K_AR, 5'd0, 3'b000, "s6_no_ped_after_walk");
        push_tr(K_GN, 2, "s4_north_default");
        east_req = 1'b1; ped_req = 1'b1;
        wait_cyc(373);
        east_req = 1'b0; ped_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(408 + 2 * i);
            ped_req = 1'b1;
            wait_cyc(409 + 2 * i);
            ped_req = 1'b0;
        end

        // Reset in the middle of yellow discards pending, then recovers.
        wait_cyc(424);
        push_spot(436, K_YN, 5'd3, 3'b010, "s5_yellow_cnt3");
        push_tr(K_YN, 10, "s5_north_yellow");
        push_tr(K_AR, 4, "s5_reset_in_yellow");
        push_spot(437, K_AR, 5'd0, 3'b000, "s5_reset_values");
        push_tr(K_GN, 2, "s5_recovery_green");
        push_spot(439, K_GN, 5'd0, 3'b000, "s5_recovery_entry");
        push_spot(460, K_GN, 5'd21, 3'b000, "s5_pending_discarded");
        east_req = 1'b1;
        wait_cyc(425);
        east_req = 1'b0;
        wait_cyc(436);
        reset = 1'b0;
        wait_cyc(437);
        reset = 1'b1;

        wait_cyc(466);
        n_checks++;
        if (tr_q.size() != 0) begin
            n_fail++;
            $display("FAIL transitions_seen: got %0d expected transitions still outstanding, want 0",
                     tr_q.size());
        end
        n_checks++;
        if (spot_q.size() != 0) begin
            n_fail++;
            $display("FAIL snapshots_seen: got %0d snapshots still outstanding, want 0",
                     spot_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/phase_scheduler.md
Name: phase_scheduler

Overview:
Demand-driven phase scheduler for the intersection. It arbitrates the shared crossing between three requesters: North approach, East approach and Pedestrian walk. Grants are round-robin with min/max green timing, yellow and all-red clearance. It drives the road lamp outputs and the walk signal, and replaces the fixed-cycle sequencing with latched-request arbitration.

Parameters:
GREEN_MIN, 10, minimum green ticks before a phase may be pre-empted
GREEN_MAX, 30, cap on green extension while the own approach still requests and others wait
YELLOW_T, 6, yellow duration in ticks
ALLRED_T, 2, all-red clearance duration in ticks
WALK_T, 15, pedestrian walk duration in ticks
CW, 5, counter width; GREEN_MAX < 2^CW is required

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clk)
tick  in  1  timebase enable, one-cycle pulse; all timers advance only on tick
north_req  in  1  North sensor / request level
east_req  in  1  East sensor / request level
ped_req  in  1  pedestrian button, may be a 1-cycle pulse
grant  out  2  00 none (all-red/yellow), 01 North, 10 East, 11 Pedestrian
north_light  out  3  {R,Y,G} one-hot
east_light  out  3  {R,Y,G} one-hot
walk  out  1  pedestrian walk lamp
state  out  3  ALLRED=0, GREEN=1, YELLOW=2, WALK=3
counter  out  CW  tick count within current state
pending  out  3  latched requests {ped,east,north}

Behaviour:
- Reset (reset==0 at posedge): state=ALLRED, counter=0, pending=000, last_served=Ped (so North ranks first), cur_phase=North. Outputs during and after reset: both lights R (100), walk=0, grant=00.
- Outputs are combinational decodes of registered state/cur_phase, with no extra latency. GREEN: served road G, other road R. YELLOW: served road Y, other R. WALK: both R, walk=1, grant=11. ALLRED: both R, grant=00. Exactly one lamp bit is set per road at all times.
- Request latching, every cycle: pending[i] <= pending[i] | req[i]. The set is suppressed for the requester currently in GREEN/WALK. A pending bit clears on the cycle its phase enters GREEN/WALK. A request arriving in the same cycle as the clear is lost (already being served).
- tick==0: state and counter hold; pending still latches.
- ALLRED: on tick, if counter==ALLRED_T-1, choose next and set counter=0; else counter+1.
  - next = first pending in round-robin order North→East→Ped, starting after last_served.
  - If nothing is pending, next = North. If North was last served, re-grant it.
  - next=Ped → WALK; otherwise GREEN with cur_phase=next. last_served<=next.
- GREEN: on tick, let n=counter+1 and other=any pending bit not belonging to cur_phase.
  - Go to YELLOW (counter=0) when other && n>=GREEN_MIN && (!own_req || n>=GREEN_MAX).
  - Otherwise counter<=min(n,GREEN_MAX). It saturates and never wraps.
  - With no other demand, green holds indefinitely.
- YELLOW: on tick, if counter==YELLOW_T-1 → ALLRED, counter=0; else counter+1.
- WALK: on tick, if counter==WALK_T-1 → ALLRED, counter=0; else counter+1. There is no yellow after WALK.
- Simultaneous requests: all latch; service follows round-robin order, one phase per ALLRED arbitration.
- Reset mid-phase: immediate return to reset values on that edge. pending is discarded.
- Illegal state encoding: next state ALLRED, counter=0.

Test Plan:
1. reset=0 for 2 cycles, then reset=1, tick=1 every cycle, no requests → ALLRED for cycles 1-2, then state=GREEN, grant=01, north_light=001 held for 100 cycles.
2. From N green at counter=3, east_req pulse 1 cycle → pending=010 next cycle. YELLOW after the 10th green tick, YELLOW 6 cycles, ALLRED 2, then grant=10, pending=000.
3. north_req held high and east pending from green start → green lasts exactly 30 ticks, then YELLOW. Same case with tick asserted every 4th cycle → timings scale ×4 and counter holds between ticks.
4. During N green, east_req and ped_req pulse in the same cycle → pending=110. Sequence is E green, then WALK with walk=1 for 15 ticks and both lights 100, then ALLRED, then N (default, nothing pending).
5. reset=0 asserted at YELLOW counter=3 → next cycle state=ALLRED, counter=0, pending=000, both lights 100. Recovery follows scenario 1.
6. Repeated ped_req while WALK is active → not latched. After WALK, pending[2]=0 and no second WALK occurs.
